matrix_op_controller: RTL and testbench

Command sequencer for the 5x5 signed int8 matrix coprocessor on the HPS-FPGA bridge. It accepts one command (opcode plus two packed 200-bit operand matrices) per start pulse. It steps a single shared 8x8 signed multiplier/adder datapath through every element, or through every multiply-accumulate for matrix product. It writes saturated int8 results into a packed result register and signals completion with a one-cycle done pulse.

---
 rtl/matrix_op_controller.sv | 193 +++++++++++++++++++
 tb/tb_matrix_op_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_controller.sv
// matrix_op_controller
// Command sequencer for the 5x5 signed int8 matrix coprocessor. One command is
// accepted per start pulse in IDLE; a single shared multiplier/adder datapath is
// stepped through every element (or every multiply-accumulate for the matrix
// product) and saturated int8 results are written into a packed result register.

module matrix_op_controller (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   opcode,
    input  logic [199:0] mat_a,
    input  logic [199:0] mat_b,
    output logic [199:0] result,
    output logic         overflow,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_SCALE  = 3'b011;
    localparam logic [2:0] OP_MATMUL = 3'b100;
    localparam logic [2:0] OP_TRANS  = 3'b101;

    state_t state, state_next;

    logic [199:0]       a_reg, b_reg;
    logic [2:0]         op_reg;
    logic [4:0]         i;
    logic [2:0]         k, row, col;
    logic signed [19:0] acc;

    logic               legal;
    logic               is_mm;
    logic               last_step;
    logic [4:0]         a_idx, b_idx, dst_idx;
    logic signed [7:0]  a_el, b_el, mul_y;
    logic signed [15:0] product;
    logic signed [19:0] a_ext, b_ext, p_ext, value;
    logic [7:0]         sat_val;
    logic               sat_hit;

    assign legal = (opcode <= OP_TRANS);
    assign is_mm = (op_reg == OP_MATMUL);
    assign last_step = (state == RUN) && (i == 5'd24) && (!is_mm || (k == 3'd4));

    // Outputs come straight from registered state, so no input reaches them combinationally.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Operand and destination addressing: row/col track i = 5*row+col alongside i.
    always_comb begin
        a_idx   = i;
        b_idx   = i;
        dst_idx = i;
        if (is_mm) begin
            a_idx = {2'b00, row} * 5'd5 + {2'b00, k};
            b_idx = {2'b00, k} * 5'd5 + {2'b00, col};
        end else if (op_reg == OP_TRANS) begin
            dst_idx = {2'b00, col} * 5'd5 + {2'b00, row};
        end
    end

    assign a_el    = a_reg[{a_idx, 3'b000} +: 8];
    assign b_el    = b_reg[{b_idx, 3'b000} +: 8];
    assign mul_y   = (op_reg == OP_SCALE) ? b_reg[7:0] : b_el;
    assign product = a_el * mul_y;
    assign a_ext   = {{12{a_el[7]}}, a_el};
    assign b_ext   = {{12{b_el[7]}}, b_el};
    assign p_ext   = {{4{product[15]}}, product};

    // Select the wide pre-saturation value for the current step of the active opcode.
    always_comb begin
        value = '0;
        case (op_reg)
            OP_ADD:    value = a_ext + b_ext;
            OP_SUB:    value = a_ext - b_ext;
            OP_MUL:    value = p_ext;
            OP_SCALE:  value = p_ext;
            OP_MATMUL: value = (k == 3'd0) ? p_ext : acc + p_ext;
            OP_TRANS:  value = a_ext;
            default:   value = '0;
        endcase
    end

    // Clamp to the int8 range and flag whenever clamping happened.
    always_comb begin
        sat_val = value[7:0];
        sat_hit = 1'b0;
        if (value > 20'sd127) begin
            sat_val = 8'h7F;
            sat_hit = 1'b1;
        end else if (value < -20'sd128) begin
            sat_val = 8'h80;
            sat_hit = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: illegal opcodes skip RUN and report through DONE immediately.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = legal ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command capture, index stepping, accumulation and result writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            result   <= '0;
            overflow <= 1'b0;
            error    <= 1'b0;
            i        <= '0;
            k        <= '0;
            row      <= '0;
            col      <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg    <= mat_a;
                        b_reg    <= mat_b;
                        op_reg   <= opcode;
                        result   <= '0;
                        overflow <= 1'b0;
                        error    <= !legal;
                        i        <= '0;
                        k        <= '0;
                        row      <= '0;
                        col      <= '0;
                        acc      <= '0;
                    end
                end
                RUN: begin
                    if (is_mm && (k != 3'd4)) begin
                        acc <= value;
                        k   <= k + 3'd1;
                    end else begin
                        result[{dst_idx, 3'b000} +: 8] <= sat_val;
                        if (sat_hit) begin
                            overflow <= 1'b1;
                        end
                        acc <= '0;
                        k   <= '0;
                        i   <= i + 5'd1;
                        if (col == 3'd4) begin
                            col <= '0;
                            row <= row + 3'd1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_op_controller.sv
// tb_matrix_op_controller
// Scoreboard bench: commands push their expected outcome into a queue, and a
// monitor pops and compares whenever the design raises done.

module tb_matrix_op_controller;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   opcode;
    logic [199:0] mat_a;
    logic [199:0] mat_b;
    logic [199:0] result;
    logic         overflow;
    logic         busy;
    logic         done;
    logic         error;

    typedef struct {
        logic [199:0] res;
        logic         ov;
        logic         err;
        int           lat;
        int           acc_edge;
    } exp_t;

    exp_t         sb[$];
    int           compared;
    int           failed;
    int           edge_count;
    int           accept_edge;
    logic [199:0] last_res;

    matrix_op_controller dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .mat_a    (mat_a),
        .mat_b    (mat_b),
        .result   (result),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so latencies can be measured from the accept edge.
    initial edge_count = 0;
    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic checkOutput(input string name, input logic [199:0] act, input logic [199:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference model: evaluates the command over whole matrices with integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [199:0] a, input logic [199:0] b);
        exp_t e;
        int   av[25];
        int   bv[25];
        int   v;
        int   s;
        e.res = '0;
        e.ov  = 1'b0;
        e.err = 1'b0;
        e.lat = 0;
        e.acc_edge = 0;
        for (int n = 0; n < 25; n++) begin
            av[n] = $signed(a[8*n +: 8]);
            bv[n] = $signed(b[8*n +: 8]);
        end
        s = bv[0];
        if (op > 3'd5) begin
            e.err = 1'b1;
            return e;
        end
        e.lat = (op == 3'd4) ? 125 : 25;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                case (op)
                    3'd0: v = av[5*r+c] + bv[5*r+c];
                    3'd1: v = av[5*r+c] - bv[5*r+c];
                    3'd2: v = av[5*r+c] * bv[5*r+c];
                    3'd3: v = av[5*r+c] * s;
                    3'd4: begin
                        v = 0;
                        for (int t = 0; t < 5; t++) v += av[5*r+t] * bv[5*t+c];
                    end
                    default: v = av[5*c+r];
                endcase
                if (v > 127) begin
                    v = 127;
                    e.ov = 1'b1;
                end else if (v < -128) begin
                    v = -128;
                    e.ov = 1'b1;
                end
                e.res[8*(5*r+c) +: 8] = 8'(v);
            end
        end
        return e;
    endfunction

    function automatic logic [199:0] fill(input logic [7:0] val);
        logic [199:0] m;
        for (int n = 0; n < 25; n++) m[8*n +: 8] = val;
        return m;
    endfunction

    function automatic logic [199:0] rand_mat();
        logic [199:0] m;
        for (int n = 0; n < 25; n++) m[8*n +: 8] = 8'($urandom);
        return m;
    endfunction

    // Issue one command in IDLE; optionally register its expected outcome.
    task automatic applyStimulus(input logic [2:0] op, input logic [199:0] a, input logic [199:0] b, input bit expect_done);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        mat_a  = a;
        mat_b  = b;
        @(posedge clk);
        #1;
        accept_edge = edge_count;
        if (expect_done) begin
            e = model(op, a, b);
            e.acc_edge = accept_edge;
            sb.push_back(e);
        end
        start  = 1'b0;
        opcode = 3'($urandom);
        mat_a  = rand_mat();
        mat_b  = rand_mat();
    endtask

    // Wait (bounded) for all outstanding commands, then confirm results hold in IDLE.
    task automatic waitIdle();
        for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL done_timeout: got %0d outstanding required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
        checkOutput("hold_result", result, last_res);
    endtask

    // Monitor: every done pulse must match the oldest expected command.
    always @(negedge clk) begin
        exp_t item;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL unexpected_done: got done=1 required done=0");
            end else begin
                item = sb.pop_front();
                checkOutput("latency", 200'(edge_count - item.acc_edge), 200'(item.lat));
                checkOutput("result", result, item.res);
                checkOutput("overflow", 200'(overflow), 200'(item.ov));
                checkOutput("error", 200'(error), 200'(item.err));
                checkOutput("busy_at_done", 200'(busy), 200'(0));
                last_res = item.res;
            end
        end
    end

    initial begin
        logic [199:0] a;
        logic [199:0] b;
        compared = 0;
        failed   = 0;
        last_res = '0;
        rst      = 1'b1;
        start    = 1'b0;
        opcode   = '0;
        mat_a    = '0;
        mat_b    = '0;

        // Reset with random inputs toggling.
        repeat (3) begin
            @(negedge clk);
            start  = 1'($urandom);
            opcode = 3'($urandom);
            mat_a  = rand_mat();
            mat_b  = rand_mat();
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("reset_result", result, '0);
        checkOutput("reset_overflow", 200'(overflow), 200'(0));
        checkOutput("reset_busy", 200'(busy), 200'(0));
        checkOutput("reset_done", 200'(done), 200'(0));
        checkOutput("reset_error", 200'(error), 200'(0));

        // Add saturating, sub without saturation.
        applyStimulus(3'b000, fill(8'd100), fill(8'd50), 1'b1);
        waitIdle();
        for (int n = 0; n < 25; n++) a[8*n +: 8] = 8'(n);
        applyStimulus(3'b001, a, fill(8'd1), 1'b1);
        waitIdle();

        // Scalar multiply: saturating then in range.
        applyStimulus(3'b011, fill(8'hFD), {rand_mat(), 8'd50} >> 8 << 8 | 200'd50, 1'b1);
        waitIdle();
        applyStimulus(3'b011, fill(8'hFE), 200'd50, 1'b1);
        waitIdle();

        // Matrix product with identity; a start at cycle 40 must be ignored.
        a = '0;
        for (int r = 0; r < 5; r++) a[8*(6*r) +: 8] = 8'd1;
        for (int n = 0; n < 25; n++) b[8*n +: 8] = 8'(n - 12);
        applyStimulus(3'b100, a, b, 1'b1);
        while (edge_count < accept_edge + 40) @(negedge clk);
        checkOutput("busy_mid_run", 200'(busy), 200'(1));
        start  = 1'b1;
        opcode = 3'b000;
        mat_a  = rand_mat();
        mat_b  = rand_mat();
        @(negedge clk);
        start = 1'b0;
        waitIdle();

        // Matrix product saturating.
        applyStimulus(3'b100, fill(8'd127), fill(8'd127), 1'b1);
        waitIdle();

        // Transpose.
        applyStimulus(3'b101, rand_mat(), rand_mat(), 1'b1);
        waitIdle();

        // Illegal opcode.
        applyStimulus(3'b111, rand_mat(), rand_mat(), 1'b1);
        checkOutput("illegal_busy", 200'(busy), 200'(0));
        waitIdle();

        // Abort a matrix product mid-run with reset; no done may follow.
        applyStimulus(3'b100, rand_mat(), rand_mat(), 1'b0);
        while (edge_count < accept_edge + 60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_result", result, '0);
        checkOutput("abort_flags", 200'({overflow, busy, done, error}), 200'(0));
        rst = 1'b0;
        repeat (140) @(negedge clk);
        last_res = '0;
        applyStimulus(3'b000, rand_mat(), rand_mat(), 1'b1);
        waitIdle();

        // Randomized commands across all opcodes.
        for (int n = 0; n < 14; n++) begin
            applyStimulus(3'($urandom_range(0, 7)), rand_mat(), rand_mat(), 1'b1);
            waitIdle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
